lcdi_interp: RTL and testbench



---
 rtl/lcdi_interp.sv | 114 +++++++++++
 tb/tb_lcdi_interp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcdi_interp.sv
// Weighted-interpolation stage for the LCDI pipeline: per-class coefficient bank,
// three-stage multiply/accumulate with round-half-up and clamp to the pixel range.
module lcdi_interp #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int IDX_WIDTH  = 7,
  parameter int NUM_CLASS  = 81
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IDX_WIDTH-1:0]    index_in,
  input  logic [DATA_WIDTH-1:0]   data0_in,
  input  logic [DATA_WIDTH-1:0]   data1_in,
  input  logic [DATA_WIDTH-1:0]   data2_in,
  input  logic                    coef_we,
  input  logic [IDX_WIDTH-1:0]    coef_addr,
  input  logic [3*COEF_WIDTH-1:0] coef_wdata,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   pix_out,
  output logic                    idx_err
);

  localparam int PW = COEF_WIDTH + DATA_WIDTH + 1;
  localparam int SW = PW + 2;
  localparam int WW = 3 * COEF_WIDTH;
  localparam logic [WW-1:0] IDENT = {COEF_WIDTH'(0), COEF_WIDTH'(64), COEF_WIDTH'(0)};
  localparam logic [IDX_WIDTH:0] NCLS = (IDX_WIDTH + 1)'(NUM_CLASS);
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << DATA_WIDTH) - 1);

  logic [WW-1:0] bank [NUM_CLASS];
  logic          wr_ok;
  logic          rd_ok;
  logic [WW-1:0] sel_w;

  logic                  v1;
  logic [DATA_WIDTH-1:0] d0_1, d1_1, d2_1;
  logic [WW-1:0]         w_1;

  logic                  v2;
  logic signed [PW-1:0]  p0_2, p1_2, p2_2;

  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  rnd;
  logic [DATA_WIDTH-1:0] pix_n;

  assign wr_ok = coef_we && ({1'b0, coef_addr} < NCLS);
  assign rd_ok = {1'b0, index_in} < NCLS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLASS; i++) bank[i] <= IDENT;
    end else if (wr_ok) begin
      bank[coef_addr] <= coef_wdata;
    end
  end

  // Read sees the bank before this edge's write, so a colliding sample gets the old weights.
  always_comb begin
    sel_w = IDENT;
    if (rd_ok) sel_w = bank[index_in];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      d0_1    <= '0;
      d1_1    <= '0;
      d2_1    <= '0;
      w_1     <= '0;
      idx_err <= 1'b0;
    end else begin
      v1   <= in_valid;
      d0_1 <= data0_in;
      d1_1 <= data1_in;
      d2_1 <= data2_in;
      w_1  <= sel_w;
      if (in_valid && !rd_ok) idx_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      p0_2 <= '0;
      p1_2 <= '0;
      p2_2 <= '0;
    end else begin
      v2   <= v1;
      p0_2 <= PW'($signed(w_1[0*COEF_WIDTH +: COEF_WIDTH])) * PW'($signed({1'b0, d0_1}));
      p1_2 <= PW'($signed(w_1[1*COEF_WIDTH +: COEF_WIDTH])) * PW'($signed({1'b0, d1_1}));
      p2_2 <= PW'($signed(w_1[2*COEF_WIDTH +: COEF_WIDTH])) * PW'($signed({1'b0, d2_1}));
    end
  end

  always_comb begin
    sum   = SW'(p0_2) + SW'(p1_2) + SW'(p2_2) + SW'(32);
    rnd   = sum >>> 6;
    pix_n = rnd[DATA_WIDTH-1:0];
    if (rnd[SW-1])          pix_n = '0;
    else if (rnd > PIX_MAX) pix_n = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pix_out   <= '0;
    end else begin
      out_valid <= v2;
      if (v2) pix_out <= pix_n;
    end
  end

endmodule

// File: tb/tb_lcdi_interp.sv
// Scoreboard bench for lcdi_interp: driver pushes expected pixels from a
// plain-arithmetic model of the weighted interpolation; a monitor pops and compares.
module tb_lcdi_interp;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  index_in;
  logic [7:0]  data0_in, data1_in, data2_in;
  logic        coef_we;
  logic [6:0]  coef_addr;
  logic [23:0] coef_wdata;
  logic        out_valid;
  logic [7:0]  pix_out;
  logic        idx_err;

  lcdi_interp #(
    .DATA_WIDTH (8),
    .COEF_WIDTH (8),
    .IDX_WIDTH  (7),
    .NUM_CLASS  (81)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .index_in   (index_in),
    .data0_in   (data0_in),
    .data1_in   (data1_in),
    .data2_in   (data2_in),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .pix_out    (pix_out),
    .idx_err    (idx_err)
  );

  typedef struct {
    int pix;
    int due;
  } exp_t;

  exp_t sb[$];
  int   mw[81][3];
  bit   merr;
  int   last_pix;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 81; c++) begin
      mw[c][0] = 0;
      mw[c][1] = 64;
      mw[c][2] = 0;
    end
    merr     = 1'b0;
    last_pix = 0;
    sb.delete();
  endfunction

  // Weighted sum, round half up (floor of (s+32)/64), clamp to 0..255.
  function automatic int ref_pix(input int idx, input int a0, input int a1, input int a2);
    int w0, w1, w2, t, q;
    if (idx < 81) begin
      w0 = mw[idx][0]; w1 = mw[idx][1]; w2 = mw[idx][2];
    end else begin
      w0 = 0; w1 = 64; w2 = 0;
    end
    t = w0 * a0 + w1 * a1 + w2 * a2 + 32;
    q = t / 64;
    if (t < 0 && (t % 64) != 0) q = q - 1;
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input bit v, input int idx, input int a0, input int a1, input int a2,
                       input bit we, input int addr, input int w0, input int w1, input int w2);
    exp_t e;
    in_valid   = v;
    index_in   = 7'(idx);
    data0_in   = 8'(a0);
    data1_in   = 8'(a1);
    data2_in   = 8'(a2);
    coef_we    = we;
    coef_addr  = 7'(addr);
    coef_wdata = {8'(w2), 8'(w1), 8'(w0)};
    @(posedge clk);
    if (v) begin
      e.pix = ref_pix(idx, a0, a1, a2);
      e.due = cyc + 3;
      sb.push_back(e);
      if (idx >= 81) merr = 1'b1;
    end
    if (we && addr < 81) begin
      mw[addr][0] = w0;
      mw[addr][1] = w1;
      mw[addr][2] = w2;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("out_valid_unexpected", int'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("pix_out", int'(pix_out), e.pix);
        last_pix = e.pix;
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("out_valid_missing", int'(out_valid), 1);
        void'(sb.pop_front());
      end
      chk("pix_hold", int'(pix_out), last_pix);
    end
    chk("idx_err", int'(idx_err), int'(merr));
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    index_in = '0;
    data0_in = '0;
    data1_in = '0;
    data2_in = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // identity default
    drive(1, 40, 10, 200, 30, 0, 0, 0, 0, 0);
    idle(3);
    // programmed entry: (1600+6400+1600+32)>>>6 = 150
    drive(0, 0, 0, 0, 0, 1, 5, 16, 32, 16);
    drive(1, 5, 100, 200, 100, 0, 0, 0, 0, 0);
    // clamps high and low
    drive(0, 0, 0, 0, 0, 1, 7, 0, 127, 0);
    drive(0, 0, 0, 0, 0, 1, 8, -64, 0, 0);
    drive(1, 7, 0, 255, 0, 0, 0, 0, 0, 0);
    drive(1, 8, 200, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // back-to-back with bubbles
    drive(1, 0, 11, 22, 33, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 44, 55, 66, 0, 0, 0, 0, 0);
    drive(1, 2, 77, 88, 99, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 254, 3, 0, 0, 0, 0, 0);
    idle(3);
    // write/read collision: old weights give 2, new weights give 3
    drive(1, 9, 1, 2, 3, 1, 9, 0, 0, 64);
    drive(1, 9, 1, 2, 3, 0, 0, 0, 0, 0);
    idle(3);
    // out-of-range index and ignored out-of-range write
    drive(1, 100, 5, 77, 9, 1, 90, 10, 10, 10);
    idle(3);
    // reset with two samples in flight; bank returns to identity
    drive(1, 5, 100, 200, 100, 0, 0, 0, 0, 0);
    drive(1, 7, 0, 255, 0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 5, 10, 20, 30, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      int idx;
      if (i == 150) do_reset();
      idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(81, 127)) : int'($urandom_range(0, 80));
      drive($urandom_range(0, 3) != 0, idx,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 90)),
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
    end

    idle(6);
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
